// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and the baud tick block.
// Contents: state encoding, parity mode codes and the oversample divisor function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    IDLE_HOLD = 3'd5
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clocks per 16x oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud * 8) / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-frame handshake bundle between the UART receiver and its consumer.
// Signals: data (received word), valid, ready, parity_err, frame_err, overrun (sticky).
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks.
// Ports: clk, reset_n (sync, active low), sync_clr (restart phase), tick.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_clr,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || sync_clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 2-of-3 majority bit decision,
// optional parity, valid/ready output with per-frame error flags and sticky overrun.
// Ports: clk, reset_n (sync, active low), RsRx (async serial in, idles high),
//        rx_if (master: data/valid/parity_err/frame_err/overrun out, ready in),
//        break_det (only when UART_RX_BREAK_DETECT_EN is defined).
// Macro UART_RX_BREAK_DETECT_EN: swallow all-zero frames, pulse break_det, wait for line high.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV       = uart_pkg::calc_div(CLK_FREQ, BAUD)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RsRx,
  uart_rx_param_if.master rx_if
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic            break_det
`endif
);
  import uart_pkg::*;

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  // Elaboration-time parameter legality.
  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_param: DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_par_chk
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic                 tick, sync_clr_c;
  logic [3:0]           samp_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 s7, s8;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;
  logic                 decide_c, bit_end_c, bit_val_c, commit_c, break_c;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 par_bit;
`endif

  // Two-flop synchroniser on the raw serial pin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RsRx;
      rx_s <= rx_m;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync_clr (sync_clr_c),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START: begin
        if (decide_c && bit_val_c) state_nxt = IDLE;   // false start
        else if (bit_end_c)        state_nxt = DATA;
      end
      DATA: begin
        if (bit_end_c && bit_idx == BW'(DATA_BITS))
          state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      end
      uart_pkg::PARITY: if (bit_end_c) state_nxt = STOP;
      STOP:      if (decide_c) state_nxt = break_c ? IDLE_HOLD : IDLE;
      IDLE_HOLD: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from state and oversample position.
  always_comb begin
    sync_clr_c = (state == IDLE) || (state == IDLE_HOLD);
    decide_c   = tick && (samp_cnt == 4'd9);
    bit_end_c  = tick && (samp_cnt == 4'd15);
    bit_val_c  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
`ifdef UART_RX_BREAK_DETECT_EN
    break_c    = (state == STOP) && decide_c && !bit_val_c && (shreg == '0) && !par_bit;
`else
    break_c    = 1'b0;
`endif
    commit_c   = (state == STOP) && decide_c && !break_c;
  end

  // Oversample counters and frame assembly.
  always_ff @(posedge clk) begin
    if (!reset_n || state == IDLE) begin
      samp_cnt  <= '0;
      bit_idx   <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      shreg     <= '0;
      par_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      if (tick) samp_cnt <= samp_cnt + 4'd1;
      if (tick && samp_cnt == 4'd7) s7 <= rx_s;
      if (tick && samp_cnt == 4'd8) s8 <= rx_s;
      if (decide_c && state == DATA) begin
        shreg   <= {bit_val_c, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (decide_c && state == uart_pkg::PARITY) begin
        // Data plus parity bit must have odd weight for odd parity, even for even.
        par_err_q <= ((^shreg) ^ bit_val_c) != (PARITY == PAR_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit   <= bit_val_c;
`endif
      end
    end
  end

  // Output register: commit, handshake and overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_if.data       <= '0;
      rx_if.valid      <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.overrun    <= 1'b0;
    end else if (commit_c) begin
      if (!rx_if.valid || rx_if.ready) begin
        rx_if.data       <= shreg;
        rx_if.parity_err <= (PARITY != PAR_NONE) && par_err_q;
        rx_if.frame_err  <= !bit_val_c;
        rx_if.valid      <= 1'b1;
      end else begin
        rx_if.overrun    <= 1'b1;
      end
    end else if (rx_if.valid && rx_if.ready) begin
      rx_if.valid <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) break_det <= 1'b0;
    else          break_det <= break_c;
  end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7O2) at DIV=10.
module tb_uart_rx_param;

  localparam int unsigned CF       = 1600000;
  localparam int unsigned BR       = 10000;
  localparam int unsigned BIT_CLKS = 160;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] rx      = 3'b111;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc      = 0;
  longint start_cyc = 0;

  int          cap_cnt  = 0;
  logic [7:0]  cap_data = '0;
  logic        cap_pe   = 1'b0;
  logic        cap_fe   = 1'b0;
  longint      cap_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7)) if_c ();

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_a, brk_b, brk_c;
  int   brk_cnt = 0;
`endif

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .RsRx(rx[0]), .rx_if(if_a)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk_a)
`endif
  );

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .RsRx(rx[1]), .rx_if(if_b)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk_b)
`endif
  );

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset_n(reset_n), .RsRx(rx[2]), .rx_if(if_c)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk_c)
`endif
  );

  // Capture every accepted 8N1 frame.
  always @(negedge clk) begin
    if (if_a.valid && if_a.ready) begin
      cap_cnt  = cap_cnt + 1;
      cap_data = if_a.data;
      cap_pe   = if_a.parity_err;
      cap_fe   = if_a.frame_err;
      cap_cyc  = cyc;
    end
`ifdef UART_RX_BREAK_DETECT_EN
    if (brk_a) brk_cnt = brk_cnt + 1;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame onto rx[idx]; par: 0 none, 1 odd, 2 even.
  task automatic send_frame(input int idx, input logic [8:0] d, input int nbits,
                            input int par, input bit bad_par, input logic stop_v,
                            input int nstop);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) p = p ^ d[i];
    if (par == 1) p = ~p;
    if (bad_par)  p = ~p;
    @(negedge clk);
    start_cyc = cyc;
    rx[idx] = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      rx[idx] = d[i];
      idle(BIT_CLKS);
    end
    if (par != 0) begin
      rx[idx] = p;
      idle(BIT_CLKS);
    end
    rx[idx] = stop_v;
    idle(BIT_CLKS);
    for (int i = 1; i < nstop; i++) begin
      rx[idx] = 1'b1;
      idle(BIT_CLKS);
    end
    rx[idx] = 1'b1;
  endtask

  initial begin
    int     c0;
    longint lat;
    if_a.ready = 1'b1;
    if_b.ready = 1'b0;
    if_c.ready = 1'b0;
    idle(3);
    check_eq("rst_valid", if_a.valid, 1'b0);
    check_eq("rst_data", if_a.data, 8'h00);
    check_eq("rst_overrun", if_a.overrun, 1'b0);
    reset_n = 1'b1;
    idle(50);

    // 8N1 0xA5, ready high: one-clk valid, clean flags, ~1544 clk latency.
    c0 = cap_cnt;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1);
    idle(200);
    lat = cap_cyc - start_cyc;
    check_eq("a5_count", cap_cnt - c0, 1);
    check_eq("a5_data", cap_data, 8'hA5);
    check_eq("a5_perr", cap_pe, 1'b0);
    check_eq("a5_ferr", cap_fe, 1'b0);
    check_eq("a5_latency", (lat >= 1500 && lat <= 1600), 1'b1);

    // Stop bit low on 0x3C, then a clean 0x41.
    c0 = cap_cnt;
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0, 1);
    idle(400);
    check_eq("3c_count", cap_cnt - c0, 1);
    check_eq("3c_data", cap_data, 8'h3C);
    check_eq("3c_ferr", cap_fe, 1'b1);
    send_frame(0, 9'h041, 8, 0, 1'b0, 1'b1, 1);
    idle(200);
    check_eq("41_data", cap_data, 8'h41);
    check_eq("41_ferr", cap_fe, 1'b0);

    // Overrun: ready low, 0x11 then 0x22 back-to-back.
    if_a.ready = 1'b0;
    c0 = cap_cnt;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1);
    idle(100);
    check_eq("ovr_valid", if_a.valid, 1'b1);
    check_eq("ovr_data", if_a.data, 8'h11);
    check_eq("ovr_flag", if_a.overrun, 1'b1);
    check_eq("ovr_nocap", cap_cnt - c0, 0);
    if_a.ready = 1'b1;
    idle(1);
    check_eq("ovr_valid_drop", if_a.valid, 1'b0);
    check_eq("ovr_sticky", if_a.overrun, 1'b1);

    // 8E1 0x07: wrong parity bit, then correct one.
    send_frame(1, 9'h007, 8, 2, 1'b1, 1'b1, 1);
    idle(200);
    check_eq("e1_bad_valid", if_b.valid, 1'b1);
    check_eq("e1_bad_data", if_b.data, 8'h07);
    check_eq("e1_bad_perr", if_b.parity_err, 1'b1);
    if_b.ready = 1'b1;
    idle(1);
    if_b.ready = 1'b0;
    send_frame(1, 9'h007, 8, 2, 1'b0, 1'b1, 1);
    idle(200);
    check_eq("e1_ok_data", if_b.data, 8'h07);
    check_eq("e1_ok_perr", if_b.parity_err, 1'b0);
    if_b.ready = 1'b1;
    idle(1);
    if_b.ready = 1'b0;

    // 7O2: 60-clk glitch is rejected, then 0x55.
    @(negedge clk);
    rx[2] = 1'b0;
    idle(60);
    rx[2] = 1'b1;
    idle(400);
    check_eq("glitch_valid", if_c.valid, 1'b0);
    send_frame(2, 9'h055, 7, 1, 1'b0, 1'b1, 2);
    idle(200);
    check_eq("o2_valid", if_c.valid, 1'b1);
    check_eq("o2_data", if_c.data, 7'h55);
    check_eq("o2_perr", if_c.parity_err, 1'b0);
    check_eq("o2_ferr", if_c.frame_err, 1'b0);

    // Reset mid-data on 8N1, then 0x81.
    @(negedge clk);
    rx[0] = 1'b0;
    idle(BIT_CLKS);
    rx[0] = 1'b1;
    idle(BIT_CLKS);
    rx[0] = 1'b0;
    idle(BIT_CLKS / 2);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    rx[0]   = 1'b1;
    check_eq("mid_rst_data", if_a.data, 8'h00);
    check_eq("mid_rst_valid", if_a.valid, 1'b0);
    check_eq("mid_rst_overrun", if_a.overrun, 1'b0);
    check_eq("mid_rst_ferr", if_a.frame_err, 1'b0);
    idle(400);
    c0 = cap_cnt;
    send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 1);
    idle(200);
    check_eq("81_count", cap_cnt - c0, 1);
    check_eq("81_data", cap_data, 8'h81);
    check_eq("81_ferr", cap_fe, 1'b0);

    // 12-bit-time low on 8N1.
    c0 = cap_cnt;
`ifdef UART_RX_BREAK_DETECT_EN
    begin
      int b0;
      b0 = brk_cnt;
      @(negedge clk);
      rx[0] = 1'b0;
      idle(12 * BIT_CLKS);
      rx[0] = 1'b1;
      idle(1800);
      check_eq("brk_pulse", brk_cnt - b0, 1);
      check_eq("brk_nocap", cap_cnt - c0, 0);
      check_eq("brk_valid", if_a.valid, 1'b0);
    end
`else
    @(negedge clk);
    rx[0] = 1'b0;
    idle(10 * BIT_CLKS);
    check_eq("brk_count", cap_cnt - c0, 1);
    check_eq("brk_data", cap_data, 8'h00);
    check_eq("brk_ferr", cap_fe, 1'b1);
    idle(2 * BIT_CLKS);
    rx[0] = 1'b1;
    idle(1800);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
